dbus_demux: RTL and testbench
=============================

# dbus_demux

Data-bus request demultiplexer for the single-cycle core's load/store path. It decodes one CPU data-memory request and routes it to one of three targets: data RAM, MMIO and timer. It then waits for that target's ready, with a timeout, and returns a single registered response carrying read data and an error flag. It is the fan-out counterpart of the read-data/write-back multiplexers: one source, many destinations.

## Interface
Parameters:
- TIMEOUT, 15, max cycles s_valid is held awaiting s_ready before error response (1..15)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  CPU request present
- req_ready  out  1  block can accept request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_wstrb  in  4  byte enables for store
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  load data (0 on store or error)
- resp_err  out  1  decode, misalign or timeout error
- m_addr  out  32  latched address, shared by all targets
- m_wdata  out  32  latched store data, shared
- m_wstrb  out  4  latched byte enables, shared
- m_we  out  1  latched write enable, shared
- s_valid  out  3  one-hot target select/valid: bit0 RAM, bit1 MMIO, bit2 timer
- s_ready  in  3  per-target completion
- s0_rdata, s1_rdata, s2_rdata  in  32 each  per-target read data

## Operation
- Address map:
  - RAM: req_addr[31:16]==16'h0000
  - MMIO: req_addr[31:12]==20'h10000
  - timer: req_addr[31:8]==24'h200000
  - anything else: decode error
- Misaligned: req_addr[1:0]!=0 is an error, whatever the target; no target is accessed.
- FSM states:
  - IDLE:
    - req_ready=1.
    - On req_valid: latch addr/wdata/wstrb/we into m_*.
    - Decode hit and aligned -> BUSY, setting s_valid to the one-hot target.
    - Otherwise -> RESP with err=1.
  - BUSY:
    - s_valid held constant; timeout counter increments each cycle.
    - s_ready[sel]=1 -> capture s<sel>_rdata (forced to 0 when m_we=1), err=0, clear s_valid, -> RESP.
    - Else if counter==TIMEOUT-1 -> rdata=0, err=1, clear s_valid, -> RESP.
    - s_ready bits of non-selected targets are ignored.
  - RESP:
    - resp_valid=1 for exactly one cycle with registered resp_rdata/resp_err, -> IDLE.
- req_ready = (state==IDLE). No new request is accepted until RESP completes: single outstanding transaction.
- Counter is 4 bits and cleared on entry to BUSY.
- m_* outputs hold their last latched value between transactions.

## Timing
- Reset (async, any state):
  - state=IDLE, s_valid=0, resp_valid=0, resp_err=0, resp_rdata=0.
  - m_addr=0, m_wdata=0, m_wstrb=0, m_we=0, counter=0.
  - req_ready=1 as soon as reset deasserts.
  - A transaction in flight is dropped, with no response.
- Handshake: request accepted at edge E0 where req_valid&&req_ready.
- Hit path:
  - s_valid high from E0 onward.
  - s_ready sampled at E1, E2, ...
  - s_ready seen at edge Ek -> resp_valid high for the cycle after Ek.
  - req_ready returns 1 one cycle after that.
  - Minimum latency, s_ready already high: resp_valid in cycle E1..E2, i.e. 2 cycles request-to-response.
- Error path, decode or misalign: resp_valid in cycle E0..E1, 1 cycle; s_valid never asserted.
- Timeout:
  - s_valid asserted for exactly TIMEOUT cycles.
  - s_ready arriving on the final cycle wins: success, not error.
- resp_valid is never high in two consecutive cycles.
- At most one s_valid bit is high at any time.

## Test plan
- Load RAM:
  - Stimulus: req addr 0x0000_0010, we=0; s_ready[0]=1 immediately; s0_rdata=0xCAFE_F00D.
  - Required: s_valid=3'b001 for 1 cycle; resp_valid 2 cycles after accept; rdata=0xCAFE_F00D; err=0.
- Store MMIO with wait:
  - Stimulus: addr 0x1000_0004, wdata 0x1234_5678, wstrb 4'hF; s_ready[1] after 3 cycles.
  - Required: m_wdata=0x1234_5678 held; s_valid=3'b010 for 3 cycles; resp rdata=0; err=0.
- Decode and misalign errors:
  - Stimulus: addr 0x3000_0000, then addr 0x0000_0002.
  - Required: each gives resp_valid 1 cycle after accept, err=1; s_valid stays 0.
- Timeout:
  - Stimulus: timer addr 0x2000_0000; s_ready never asserted; TIMEOUT=15.
  - Required: s_valid=3'b100 for exactly 15 cycles; then resp err=1, rdata=0.
  - Repeat with s_ready on cycle 15. Required: err=0.
- Wrong-target ready and reset mid-BUSY:
  - Stimulus: RAM access with s_ready=3'b110.
  - Required: no response until s_ready[0].
  - Stimulus: reset asserted during BUSY.
  - Required: s_valid=0 immediately; no resp_valid; next request proceeds normally.

Source files
------------

// File: rtl/dbus_demux.sv
// Data-bus request demultiplexer: decodes one CPU load/store, drives a single target,
// waits for its ready (bounded by TIMEOUT) and returns one registered response.
module dbus_demux #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_we,
  output logic [2:0]  s_valid,
  input  logic [2:0]  s_ready,
  input  logic [31:0] s0_rdata,
  input  logic [31:0] s1_rdata,
  input  logic [31:0] s2_rdata
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_t;

  localparam logic [3:0] LastCnt = 4'(TIMEOUT - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [2:0]  dec_sel;
  logic        aligned;
  logic        sel_ready;
  logic [31:0] sel_rdata;

  always_comb begin
    dec_sel[0] = (req_addr[31:16] == 16'h0000);
    dec_sel[1] = (req_addr[31:12] == 20'h10000);
    dec_sel[2] = (req_addr[31:8] == 24'h200000);
    aligned    = (req_addr[1:0] == 2'b00);
  end

  // Only the selected target's ready counts; others are masked by the one-hot select.
  assign sel_ready = |(s_ready & s_valid);

  always_comb begin
    sel_rdata = '0;
    if (s_valid[0])      sel_rdata = s0_rdata;
    else if (s_valid[1]) sel_rdata = s1_rdata;
    else if (s_valid[2]) sel_rdata = s2_rdata;
  end

  assign req_ready = (state == StIdle);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      cnt        <= '0;
      s_valid    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_wstrb    <= '0;
      m_we       <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          resp_valid <= 1'b0;
          if (req_valid) begin
            m_addr  <= req_addr;
            m_wdata <= req_wdata;
            m_wstrb <= req_wstrb;
            m_we    <= req_we;
            if ((|dec_sel) && aligned) begin
              s_valid <= dec_sel;
              cnt     <= '0;
              state   <= StBusy;
            end else begin
              resp_rdata <= '0;
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              state      <= StResp;
            end
          end
        end
        StBusy: begin
          cnt <= cnt + 4'd1;
          // Ready on the final cycle is checked first, so it beats the timeout.
          if (sel_ready) begin
            resp_rdata <= m_we ? 32'h0 : sel_rdata;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            s_valid    <= '0;
            state      <= StResp;
          end else if (cnt == LastCnt) begin
            resp_rdata <= '0;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            s_valid    <= '0;
            state      <= StResp;
          end
        end
        StResp: begin
          resp_valid <= 1'b0;
          state      <= StIdle;
        end
        default: begin
          resp_valid <= 1'b0;
          s_valid    <= '0;
          state      <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_demux.sv
// Randomized scoreboard bench for dbus_demux: expected responses are queued at issue
// time and checked by an independent monitor on each resp_valid pulse.
module tb_dbus_demux;

  localparam int T = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_we;
  logic [2:0]  s_valid, s_ready;
  logic [31:0] s0_rdata, s1_rdata, s2_rdata;

  dbus_demux #(.TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_we(m_we),
    .s_valid(s_valid), .s_ready(s_ready),
    .s0_rdata(s0_rdata), .s1_rdata(s1_rdata), .s2_rdata(s2_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          at_cyc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic prev_resp = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every response pulse and checks bus invariants.
  always @(negedge clk) begin
    chk("s_valid_onehot", 32'($countones(s_valid) <= 1), 32'd1);
    if (resp_valid) begin
      chk("resp_not_back_to_back", 32'(prev_resp), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_cycle", 32'(cyc), 32'(e.at_cyc));
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", 32'(resp_err), 32'(e.err));
      end
    end
    prev_resp = resp_valid;
  end

  // Reference decode straight from the address map.
  function automatic logic [2:0] target(input logic [31:0] a);
    if (a[1:0] != 2'b00) return 3'b000;
    if (a[31:16] == 16'h0000) return 3'b001;
    if (a[31:12] == 20'h10000) return 3'b010;
    if (a[31:8] == 24'h200000) return 3'b100;
    return 3'b000;
  endfunction

  // k: edge index (after accept) at which the selected ready is first presented.
  task automatic do_req(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int k, input logic [31:0] dat,
                        input logic [2:0] noise);
    logic [2:0]  sel;
    int          last;
    bit          ok;
    exp_t        e;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      chk("req_ready_timeout", 32'd0, 32'd1);
      return;
    end
    sel = target(addr);
    s0_rdata = $urandom; s1_rdata = $urandom; s2_rdata = $urandom;
    if (sel == 3'b001) s0_rdata = dat;
    if (sel == 3'b010) s1_rdata = dat;
    if (sel == 3'b100) s2_rdata = dat;
    last = (sel == 3'b000) ? 0 : ((k <= T) ? k : T);
    e.at_cyc = cyc + 1 + last;
    e.err    = (sel == 3'b000) || (k > T);
    e.rdata  = (e.err || we) ? 32'h0 : dat;
    exp_q.push_back(e);
    req_valid = 1'b1; req_addr = addr; req_we = we; req_wdata = wdata; req_wstrb = wstrb;
    s_ready = noise & ~sel;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'($urandom); req_we = 1'($urandom);
    chk("m_addr", m_addr, addr);
    chk("m_wdata", m_wdata, wdata);
    chk("m_wstrb", 32'(m_wstrb), 32'(wstrb));
    chk("m_we", 32'(m_we), 32'(we));
    for (int j = 1; j <= last; j++) begin
      chk("s_valid_busy", 32'(s_valid), 32'(sel));
      s_ready = (noise & ~sel) | ((j >= k) ? sel : 3'b000);
      @(negedge clk);
    end
    chk("s_valid_done", 32'(s_valid), 32'd0);
    chk("m_wdata_held", m_wdata, wdata);
    s_ready = 3'b000;
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  kind;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_wstrb = '0; s_ready = '0; s0_rdata = '0; s1_rdata = '0; s2_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_s_valid", 32'(s_valid), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_m_wstrb_we", 32'({m_wstrb, m_we}), 32'd0);
    reset = 1'b0;
    #1 chk("rst_req_ready", 32'(req_ready), 32'd1);

    do_req(32'h0000_0010, 1'b0, 32'h0, 4'h0, 1, 32'hCAFE_F00D, 3'b000);
    do_req(32'h1000_0004, 1'b1, 32'h1234_5678, 4'hF, 3, 32'hDEAD_BEEF, 3'b000);
    do_req(32'h3000_0000, 1'b0, 32'h0, 4'h0, 1, 32'h1111_1111, 3'b000);
    do_req(32'h0000_0002, 1'b0, 32'h0, 4'h0, 1, 32'h2222_2222, 3'b000);
    do_req(32'h2000_0000, 1'b0, 32'h0, 4'h0, 99, 32'h3333_3333, 3'b000);
    do_req(32'h2000_0000, 1'b0, 32'h0, 4'h0, 15, 32'h4444_4444, 3'b000);
    do_req(32'h0000_0100, 1'b0, 32'h0, 4'h0, 4, 32'h5555_5555, 3'b110);

    // Reset mid-BUSY: transaction dropped, no response.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h0000_0020; req_we = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("busy_s_valid", 32'(s_valid), 32'd1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("midrst_s_valid", 32'(s_valid), 32'd0);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    do_req(32'h0000_0040, 1'b0, 32'h0, 4'h0, 2, 32'h6666_6666, 3'b000);

    for (int n = 0; n < 60; n++) begin
      kind = 3'($urandom_range(0, 5));
      case (kind)
        3'd0: a = {16'h0000, 16'($urandom) & 16'hFFFC};
        3'd1: a = {20'h10000, 12'($urandom) & 12'hFFC};
        3'd2: a = {24'h200000, 8'($urandom) & 8'hFC};
        3'd3: a = {24'h200000, 8'($urandom) | 8'h01};
        default: a = $urandom;
      endcase
      do_req(a, 1'($urandom), $urandom, 4'($urandom), $urandom_range(1, 18), $urandom,
             3'($urandom));
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
